// File: rtl/conv_interleaver_if.sv
`default_nettype none
// ============================================================================
// conv_interleaver_if : symbol stream in / commutated symbol stream out
// Revision 1.0
// ============================================================================
interface conv_interleaver_if #(
    parameter int DATA_W   = 8,
    parameter int BRANCHES = 12
);
    localparam int BR_W = $clog2(BRANCHES);

    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              sync_in;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic [BR_W-1:0]   out_branch;

    modport master (
        output in_valid, data_in, sync_in,
        input  out_valid, data_out, out_branch
    );

    modport slave (
        input  in_valid, data_in, sync_in,
        output out_valid, data_out, out_branch
    );
endinterface
`default_nettype wire

// File: rtl/conv_interleaver.sv
`default_nettype none
// ============================================================================
// conv_interleaver : Forney convolutional interleaver (MODE=0) / deinterleaver (MODE=1)
// Revision 1.0
// ============================================================================
module conv_interleaver #(
    parameter int DATA_W     = 8,
    parameter int BRANCHES   = 12,
    parameter int CELL_DEPTH = 17,
    parameter int MODE       = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    conv_interleaver_if.slave bus
);
    localparam int BR_W = $clog2(BRANCHES);

    logic [BR_W-1:0]   r_ptr;
    logic [BR_W-1:0]   w_sel;
    logic              w_last;
    logic [DATA_W-1:0] w_leave [BRANCHES];

    logic              r_out_valid;
    logic [DATA_W-1:0] r_data_out;
    logic [BR_W-1:0]   r_out_branch;

    // sync only re-points the commutator for the current symbol
    assign w_sel  = bus.sync_in ? '0 : r_ptr;
    assign w_last = (w_sel == BR_W'(BRANCHES - 1));

    generate
        for (genvar gi = 0; gi < BRANCHES; gi++) begin : g_branch
            localparam int DEPTH = (MODE == 0) ? gi * CELL_DEPTH
                                               : (BRANCHES - 1 - gi) * CELL_DEPTH;
            if (DEPTH == 0) begin : g_pass
                assign w_leave[gi] = bus.data_in;
            end else begin : g_delay
                logic [DATA_W-1:0] r_cells [DEPTH];
                logic              w_shift;

                assign w_shift     = bus.in_valid && (w_sel == BR_W'(gi));
                assign w_leave[gi] = r_cells[DEPTH-1];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int j = 0; j < DEPTH; j++) begin
                            r_cells[j] <= '0;
                        end
                    end else if (w_shift) begin
                        r_cells[0] <= bus.data_in;
                        for (int j = 1; j < DEPTH; j++) begin
                            r_cells[j] <= r_cells[j-1];
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_out_valid  <= 1'b0;
            r_data_out   <= '0;
            r_out_branch <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_ptr        <= w_last ? '0 : w_sel + BR_W'(1);
                r_data_out   <= w_leave[w_sel];
                r_out_branch <= w_sel;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.data_out   = r_data_out;
    assign bus.out_branch = r_out_branch;
endmodule
`default_nettype wire

// File: tb/tb_conv_interleaver.sv
`default_nettype none
// ============================================================================
// tb_conv_interleaver : scoreboard bench for small (3x2) and default (12x17) pairs
// Revision 1.0
// ============================================================================
module tb_conv_interleaver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    conv_interleaver_if #(.DATA_W(8), .BRANCHES(3))  s_if ();
    conv_interleaver_if #(.DATA_W(8), .BRANCHES(3))  d_if ();
    conv_interleaver_if #(.DATA_W(8), .BRANCHES(12)) l_if ();
    conv_interleaver_if #(.DATA_W(8), .BRANCHES(12)) m_if ();

    conv_interleaver #(.DATA_W(8), .BRANCHES(3), .CELL_DEPTH(2), .MODE(0))
        u_s (.clk(clk), .reset(reset), .bus(s_if.slave));
    conv_interleaver #(.DATA_W(8), .BRANCHES(3), .CELL_DEPTH(2), .MODE(1))
        u_d (.clk(clk), .reset(reset), .bus(d_if.slave));
    conv_interleaver #(.DATA_W(8), .BRANCHES(12), .CELL_DEPTH(17), .MODE(0))
        u_l (.clk(clk), .reset(reset), .bus(l_if.slave));
    conv_interleaver #(.DATA_W(8), .BRANCHES(12), .CELL_DEPTH(17), .MODE(1))
        u_m (.clk(clk), .reset(reset), .bus(m_if.slave));

    // deinterleavers are aligned on the interleaver's branch-0 output
    assign d_if.in_valid = s_if.out_valid;
    assign d_if.data_in  = s_if.data_out;
    assign d_if.sync_in  = s_if.out_valid && (s_if.out_branch == 2'd0);
    assign m_if.in_valid = l_if.out_valid;
    assign m_if.data_in  = l_if.data_out;
    assign m_if.sync_in  = l_if.out_valid && (l_if.out_branch == 4'd0);

    typedef struct {
        logic [7:0] d;
        logic [1:0] b;
    } exp_t;

    exp_t       eq[$];
    int         mptr;
    int         bc [3];
    logic [7:0] bh [3][256];
    logic [7:0] obs_d, last_d;
    logic [1:0] obs_b, last_b;
    logic [7:0] t1_exp [9] = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd7, 8'd2, 8'd0};

    // Reference for the 3-branch, 2-cell interleaver: per-branch symbol history
    function automatic void model_push(input logic [7:0] d, input logic s);
        int   b;
        int   dep;
        exp_t e;
        b   = s ? 0 : mptr;
        dep = b * 2;
        bh[b][bc[b]] = d;
        e.d = (bc[b] >= dep) ? bh[b][bc[b] - dep] : 8'h00;
        e.b = 2'(b);
        bc[b]++;
        eq.push_back(e);
        mptr = (b == 2) ? 0 : b + 1;
    endfunction

    task automatic do_reset();
        #2 reset = 1'b1;
        s_if.in_valid = 1'b0; s_if.data_in = '0; s_if.sync_in = 1'b0;
        l_if.in_valid = 1'b0; l_if.data_in = '0; l_if.sync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mptr = 0;
        for (int i = 0; i < 3; i++) bc[i] = 0;
        eq.delete();
        last_d = '0;
        last_b = '0;
    endtask

    task automatic step_small(input logic v, input logic [7:0] d, input logic s);
        exp_t e;
        s_if.in_valid = v;
        s_if.data_in  = d;
        s_if.sync_in  = s;
        if (v) model_push(d, s);
        @(posedge clk);
        #1;
        obs_d = s_if.data_out;
        obs_b = s_if.out_branch;
        checks++;
        if (v) begin
            e = eq.pop_front();
            if (s_if.out_valid !== 1'b1 || obs_d !== e.d || obs_b !== e.b) begin
                failures++;
                $display("FAIL step_out: valid=%b data=%0d branch=%0d, expected valid=1 data=%0d branch=%0d",
                         s_if.out_valid, obs_d, obs_b, e.d, e.b);
            end
        end else if (s_if.out_valid !== 1'b0 || obs_d !== last_d || obs_b !== last_b) begin
            failures++;
            $display("FAIL step_gap: valid=%b data=%0d branch=%0d, expected valid=0 data=%0d branch=%0d",
                     s_if.out_valid, obs_d, obs_b, last_d, last_b);
        end
        last_d = obs_d;
        last_b = obs_b;
        s_if.in_valid = 1'b0;
        s_if.sync_in  = 1'b0;
    endtask

    task automatic run_t1(input int n);
        for (int k = 0; k < n; k++) begin
            step_small(1'b1, 8'(k + 1), 1'b0);
            if (k < 9) begin
                checks++;
                if (obs_d !== t1_exp[k]) begin
                    failures++;
                    $display("FAIL t1_value[%0d]: got %0d, expected %0d", k, obs_d, t1_exp[k]);
                end
            end
            if (k == 14) begin
                checks++;
                if (obs_d !== 8'd3 || obs_b !== 2'd2) begin
                    failures++;
                    $display("FAIL t1_value[14]: got %0d/br%0d, expected 3/br2", obs_d, obs_b);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_if.out_valid, s_if.data_out, s_if.out_branch} !== '0 ||
            {d_if.out_valid, d_if.data_out, d_if.out_branch} !== '0 ||
            {l_if.out_valid, l_if.data_out, l_if.out_branch} !== '0 ||
            {m_if.out_valid, m_if.data_out, m_if.out_branch} !== '0) begin
            failures++;
            $display("FAIL reset_state: s=%b/%0d/%0d l=%b/%0d/%0d, expected all 0",
                     s_if.out_valid, s_if.data_out, s_if.out_branch,
                     l_if.out_valid, l_if.data_out, l_if.out_branch);
        end
    endtask

    task automatic test_fill();
        do_reset();
        run_t1(15);
    endtask

    task automatic test_gaps();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            repeat ($urandom_range(0, 3)) step_small(1'b0, 8'($urandom), 1'($urandom));
            step_small(1'b1, 8'(k + 1), 1'b0);
            if (k < 9) begin
                checks++;
                if (obs_d !== t1_exp[k]) begin
                    failures++;
                    $display("FAIL gap_value[%0d]: got %0d, expected %0d", k, obs_d, t1_exp[k]);
                end
            end
        end
    endtask

    task automatic test_sync();
        do_reset();
        step_small(1'b1, 8'd1, 1'b0);
        step_small(1'b1, 8'd2, 1'b0);
        step_small(1'b1, 8'd3, 1'b1);
        checks++;
        if (obs_b !== 2'd0) begin
            failures++;
            $display("FAIL sync_branch: got %0d, expected 0", obs_b);
        end
        step_small(1'b1, 8'd4, 1'b0);
        checks++;
        if (obs_b !== 2'd1) begin
            failures++;
            $display("FAIL sync_next: got %0d, expected 1", obs_b);
        end
        step_small(1'b0, 8'd99, 1'b1);
        step_small(1'b1, 8'd5, 1'b0);
        checks++;
        if (obs_b !== 2'd2) begin
            failures++;
            $display("FAIL sync_idle_ignored: got %0d, expected 2", obs_b);
        end
        step_small(1'b1, 8'd6, 1'b1);
        step_small(1'b1, 8'd7, 1'b1);
        checks++;
        if (obs_b !== 2'd0) begin
            failures++;
            $display("FAIL sync_repeat: got %0d, expected 0", obs_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_t1(20);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (s_if.out_valid !== 1'b0 || s_if.data_out !== 8'd0 || s_if.out_branch !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: valid=%b data=%0d branch=%0d, expected 0/0/0",
                     s_if.out_valid, s_if.data_out, s_if.out_branch);
        end
        @(posedge clk);
        #1;
        do_reset();
        run_t1(15);
    endtask

    task automatic test_round_trip(input bit big, input int n);
        logic [7:0] q[$];
        logic [7:0] r, od, ev;
        logic       v, ov;
        int         dly;
        do_reset();
        dly = big ? 2244 : 12;
        for (int i = 0; i < dly; i++) q.push_back(8'h00);
        for (int k = 0; k < n + 2; k++) begin
            v = (k < n);
            r = 8'($urandom);
            if (big) begin
                l_if.in_valid = v; l_if.data_in = r; l_if.sync_in = (k == 0);
            end else begin
                s_if.in_valid = v; s_if.data_in = r; s_if.sync_in = (k == 0);
            end
            if (v) q.push_back(r);
            @(posedge clk);
            #1;
            ov = big ? m_if.out_valid : d_if.out_valid;
            od = big ? m_if.data_out  : d_if.data_out;
            checks++;
            if (k == 0 || k == n + 1) begin
                if (ov !== 1'b0) begin
                    failures++;
                    $display("FAIL rt_latency(big=%0d,k=%0d): out_valid=%b, expected 0", big, k, ov);
                end
            end else if (ov !== 1'b1) begin
                failures++;
                $display("FAIL rt_valid(big=%0d,k=%0d): out_valid=%b, expected 1", big, k, ov);
            end else begin
                ev = q.pop_front();
                if (od !== ev) begin
                    failures++;
                    $display("FAIL rt_data(big=%0d,k=%0d): got %0d, expected %0d", big, k, od, ev);
                end
            end
        end
        s_if.in_valid = 1'b0; s_if.sync_in = 1'b0;
        l_if.in_valid = 1'b0; l_if.sync_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        s_if.in_valid = 1'b0; s_if.data_in = '0; s_if.sync_in = 1'b0;
        l_if.in_valid = 1'b0; l_if.data_in = '0; l_if.sync_in = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_gaps();
        test_sync();
        test_round_trip(1'b0, 60);
        test_reset_mid();
        test_round_trip(1'b1, 10000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
